// File: rtl/decoder_2_to_4_hold.sv
// Registered 2-to-4 decoder: one cycle from accept to one-hot y, then y is held for HOLD_CYCLES cycles.
// in_ready is low while holding and rises on the last hold cycle so a new code can be accepted back-to-back.
module decoder_2_to_4_hold #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] in_code,
   output logic       in_ready,
   output logic [3:0] y,
   output logic       y_valid,
   output logic       done
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [3:0]       y_nxt;
   logic             last;
   logic             accept;

   assign last   = (cnt == LAST);
   assign accept = in_valid & in_ready;

   // State, counter and the held one-hot value share one register process
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         y     <= 4'b0000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         y     <= y_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      y_nxt     = y;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
               y_nxt     = 4'b0001 << in_code;
            end
         end
         HOLD: begin
            if (!last) begin
               cnt_nxt = cnt + ONE;
            end else if (accept) begin
               cnt_nxt = '0;
               y_nxt   = 4'b0001 << in_code;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               y_nxt     = 4'b0000;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            y_nxt     = 4'b0000;
         end
      endcase
   end

   // Outputs depend on registers only, never on in_valid
   always_comb begin
      in_ready = (state == IDLE) || last;
      done     = (state == HOLD) && last;
      y_valid  = (state == HOLD);
   end

endmodule

// File: tb/tb_decoder_2_to_4_hold.sv
// Directed bench for decoder_2_to_4_hold with a remaining-cycles reference model checked every cycle.
module tb_decoder_2_to_4_hold;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] in_code;
   logic       in_ready;
   logic [3:0] y;
   logic       y_valid;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   decoder_2_to_4_hold #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_code  (in_code),
      .in_ready (in_ready),
      .y        (y),
      .y_valid  (y_valid),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: remaining cycles of the current value plus that value
   int         m_left;
   logic [3:0] m_val;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_val  <= 4'b0000;
      end else if (in_valid && m_left <= 1) begin
         m_left <= HOLD;
         case (in_code)
            2'd0:    m_val <= 4'd1;
            2'd1:    m_val <= 4'd2;
            2'd2:    m_val <= 4'd4;
            default: m_val <= 4'd8;
         endcase
      end else if (m_left > 1) begin
         m_left <= m_left - 1;
      end else begin
         m_left <= 0;
         m_val  <= 4'b0000;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         cmp("model_y",       32'(y),        32'(m_val));
         cmp("model_y_valid", 32'(y_valid),  32'(m_left > 0));
         cmp("model_done",    32'(done),     32'(m_left == 1));
         cmp("model_ready",   32'(in_ready), 32'(m_left <= 1));
         cmp("onehot0",       32'($onehot0(y)), 32'(1));
         cmp("zero_iff_idle", 32'(y == 4'b0000), 32'(!y_valid));
      end
   end

   // Present a code and hold it until accepted; returns at the negedge after the accept edge
   task automatic send(input logic [1:0] c);
      bit ok = 0;
      in_valid = 1'b1;
      in_code  = c;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (in_ready) ok = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: code %0d never accepted", c);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_code  = 2'd0;

      // 1. reset values before any clock edge
      #2;
      cmp("rst_y",       32'(y),        32'h0);
      cmp("rst_y_valid", 32'(y_valid),  32'h0);
      cmp("rst_ready",   32'(in_ready), 32'h1);
      cmp("rst_done",    32'(done),     32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // 2. single code 2
      in_valid = 1'b1;
      in_code  = 2'd2;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cmp("single_y",     32'(y),        32'h4);
         cmp("single_valid", 32'(y_valid),  32'h1);
         cmp("single_ready", 32'(in_ready), 32'(i == 4));
         cmp("single_done",  32'(done),     32'(i == 4));
         @(negedge clk);
      end
      cmp("single_end_y",     32'(y),       32'h0);
      cmp("single_end_valid", 32'(y_valid), 32'h0);
      idle(2);

      // 3. decode sweep
      for (int c = 0; c < 4; c++) begin
         send(2'(c));
         cmp("sweep_y", 32'(y), 32'(1 << c));
      end
      idle(6);

      // 4. back-to-back: code 1 then code 3 held continuously
      in_valid = 1'b1;
      in_code  = 2'd1;
      @(negedge clk);
      in_code  = 2'd3;
      for (int i = 1; i <= 8; i++) begin
         cmp("b2b_y",     32'(y),       (i <= 4) ? 32'h2 : 32'h8);
         cmp("b2b_valid", 32'(y_valid), 32'h1);
         cmp("b2b_done",  32'(done),    32'(i == 4 || i == 8));
         if (i == 5) in_valid = 1'b0;
         @(negedge clk);
      end
      cmp("b2b_end_valid", 32'(y_valid), 32'h0);
      idle(2);

      // 5. request while busy is ignored until the done cycle
      in_valid = 1'b1;
      in_code  = 2'd0;
      @(negedge clk);
      in_code  = 2'd3;
      for (int i = 1; i <= 4; i++) begin
         cmp("busy_y", 32'(y), 32'h1);
         @(negedge clk);
      end
      cmp("busy_next_y", 32'(y), 32'h8);
      in_valid = 1'b0;
      idle(6);

      // 6. asynchronous reset mid-hold
      in_valid = 1'b1;
      in_code  = 2'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      cmp("mid_pre_y", 32'(y), 32'h4);
      #2 rst = 1'b1;
      #1;
      cmp("mid_rst_y",     32'(y),        32'h0);
      cmp("mid_rst_valid", 32'(y_valid),  32'h0);
      cmp("mid_rst_ready", 32'(in_ready), 32'h1);
      cmp("mid_rst_done",  32'(done),     32'h0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_code  = 2'd1;
      @(negedge clk);
      in_valid = 1'b0;
      cmp("post_rst_y",     32'(y),       32'h2);
      cmp("post_rst_valid", 32'(y_valid), 32'h1);
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
